// File: rtl/spike_counter_pkg.sv
// Shared types and helpers for the multi-channel spike counter.
// FSM states, spike count mode encodings and a saturating increment.
package spike_counter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        COUNT
    } state_t;

    localparam logic MODE_EDGE  = 1'b0;
    localparam logic MODE_LEVEL = 1'b1;

    // Callers zero-extend into 64 bits; max_val is the all-ones value of their count width.
    function automatic logic [63:0] sat_inc(input logic [63:0] val, input logic inc,
                                            input logic [63:0] max_val);
        return (inc && (val != max_val)) ? val + 64'd1 : val;
    endfunction

endpackage

// File: rtl/spike_chan_cnt.sv
// One spike channel: edge/level detect, saturating live count, held count and sticky
// saturation flag, sequenced by window strobes from the top level.
module spike_chan_cnt
    import spike_counter_pkg::*;
#(
    parameter int unsigned CW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          spike,
    input  logic          sample_en,
    input  logic          tick,
    input  logic          terminal,
    input  logic          clear,
    input  logic          discard,
    input  logic          mode,
    output logic [CW-1:0] held,
    output logic          sat
);

    localparam logic [CW-1:0] MAX = '1;

    logic          prev;
    logic [CW-1:0] live;
    logic          inc;
    logic [CW-1:0] sum;

    always_comb begin
        inc = (mode == MODE_EDGE) ? (spike & ~prev) : spike;
        sum = CW'(sat_inc(64'(live), inc, 64'(MAX)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev <= 1'b0;
            live <= '0;
            held <= '0;
            sat  <= 1'b0;
        end else begin
            if (sample_en) begin
                prev <= spike;
            end
            if (clear) begin
                live <= '0;
                held <= '0;
                sat  <= 1'b0;
            end else if (discard) begin
                live <= '0;
            end else if (tick) begin
                // The terminal tick's own spike belongs to the window being closed.
                if (terminal) begin
                    held <= sum;
                    live <= '0;
                end else begin
                    live <= sum;
                end
                if (sum == MAX) begin
                    sat <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spike_counter_multi.sv
// Multi-channel windowed spike counter: FSM, window timer, window index and
// registered readout mux over per-channel held counts.
module spike_counter_multi
    import spike_counter_pkg::*;
#(
    parameter int unsigned NCH   = 8,
    parameter int unsigned CW    = 32,
    parameter int unsigned WIN_W = 16,
    parameter int unsigned SEL_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   spike_in,
    input  logic             sample_en,
    input  logic             enable,
    input  logic             mode,
    input  logic [WIN_W-1:0] win_len,
    input  logic             clear,
    input  logic [SEL_W-1:0] rd_sel,
    output logic [CW-1:0]    rd_cnt,
    output logic             win_done,
    output logic [15:0]      win_idx,
    output logic [NCH-1:0]   sat_flags,
    output logic             busy
);

    state_t           state;
    logic [WIN_W-1:0] timer;
    logic [WIN_W-1:0] len_q;
    logic [WIN_W-1:0] len_eff;
    logic             tick;
    logic             terminal;
    logic [CW-1:0]    held     [NCH];
    logic [CW-1:0]    held_pad [2**SEL_W];

    // A zero timer marks a window start, where win_len is taken fresh; otherwise the latched length.
    always_comb begin
        tick     = sample_en && enable && (state != IDLE);
        len_eff  = (timer == '0) ? ((win_len == '0) ? WIN_W'(1) : win_len) : len_q;
        terminal = tick && (timer == len_eff - WIN_W'(1));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else if (!enable) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            busy <= 1'b1;
            case (state)
                IDLE:    state <= ARM;
                ARM:     if (sample_en) state <= COUNT;
                COUNT:   state <= COUNT;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer    <= '0;
            len_q    <= '0;
            win_idx  <= '0;
            win_done <= 1'b0;
        end else begin
            win_done <= terminal && !clear;
            if (clear || !enable) begin
                timer <= '0;
            end else if (tick) begin
                timer <= terminal ? '0 : timer + WIN_W'(1);
            end
            if (tick && (timer == '0)) begin
                len_q <= len_eff;
            end
            if (clear) begin
                win_idx <= '0;
            end else if (terminal) begin
                win_idx <= win_idx + 16'd1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        spike_chan_cnt #(.CW(CW)) u_chan (
            .clk       (clk),
            .reset     (reset),
            .spike     (spike_in[i]),
            .sample_en (sample_en),
            .tick      (tick),
            .terminal  (terminal),
            .clear     (clear),
            .discard   (!enable),
            .mode      (mode),
            .held      (held[i]),
            .sat       (sat_flags[i])
        );
        assign held_pad[i] = held[i];
    end

    // Select codes beyond the last channel read back as zero.
    for (genvar i = NCH; i < 2**SEL_W; i++) begin : g_pad
        assign held_pad[i] = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt <= '0;
        end else begin
            rd_cnt <= held_pad[rd_sel];
        end
    end

endmodule
